// File: rtl/lstm_gate_scheduler.sv
// ----------------------------------------------------------------------------
// lstm_gate_scheduler
//
// Time-shares one external multiply-add unit (out = W0*X + W1*h + b) across
// the four LSTM gate pre-activations i, f, g, o.
//
// A sample (x_t, h_{t-1}) is accepted over a valid/ready handshake. The four
// gate operand sets are then issued to the shared unit in fixed order
// (i, f, g, o). Each result is captured into its gate register. Finally the
// four pre-activations are presented together over a second valid/ready
// handshake.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   sample handshake (x_in, h_in)
//   w_cfg, b_cfg          live weight / bias configuration, static while busy
//   mac_x .. mac_b        operands to the shared unit, held between issues
//   mac_out               result from the shared unit
//   out_valid / out_ready result handshake (gate_i, gate_f, gate_g, gate_o)
//   busy                  high whenever the scheduler is not idle
//
// Parameters
//   DATA_WIDTH   width of every data word
//   FRACT_WIDTH  fixed-point fraction bits; carried for the datapath owner only
//   MAC_LATENCY  cycles from operand issue to a valid mac_out (0 = combinational)
// ----------------------------------------------------------------------------
module lstm_gate_scheduler #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int MAC_LATENCY = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   x_in,
    input  logic [DATA_WIDTH-1:0]   h_in,
    input  logic [8*DATA_WIDTH-1:0] w_cfg,
    input  logic [4*DATA_WIDTH-1:0] b_cfg,
    output logic [DATA_WIDTH-1:0]   mac_x,
    output logic [DATA_WIDTH-1:0]   mac_h,
    output logic [DATA_WIDTH-1:0]   mac_w0,
    output logic [DATA_WIDTH-1:0]   mac_w1,
    output logic [DATA_WIDTH-1:0]   mac_b,
    input  logic [DATA_WIDTH-1:0]   mac_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   gate_i,
    output logic [DATA_WIDTH-1:0]   gate_f,
    output logic [DATA_WIDTH-1:0]   gate_g,
    output logic [DATA_WIDTH-1:0]   gate_o,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Wait counter runs 0 .. MAC_LATENCY-1; kept at least one bit wide so the
    // MAC_LATENCY=0 build still elaborates (the WAIT state is unreachable there).
    localparam int CNT_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (MAC_LATENCY > 0) ? CNT_W'(MAC_LATENCY - 1) : '0;

    state_t                       state;
    state_t                       state_next;
    logic [1:0]                   gate_idx;
    logic [CNT_W-1:0]             wait_cnt;
    logic [DATA_WIDTH-1:0]        x_lat;
    logic [DATA_WIDTH-1:0]        h_lat;
    logic [DATA_WIDTH-1:0]        w0_q;
    logic [DATA_WIDTH-1:0]        w1_q;
    logic [DATA_WIDTH-1:0]        b_q;
    logic [3:0][DATA_WIDTH-1:0]   gate_q;

    logic                         accept;
    logic                         capture;
    logic                         load_ops;
    logic [1:0]                   load_idx;

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (MAC_LATENCY == 0) begin
                    capture    = 1'b1;
                    state_next = (gate_idx == 2'd3) ? DONE : ISSUE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == CNT_LAST) begin
                    capture    = 1'b1;
                    state_next = (gate_idx == 2'd3) ? DONE : ISSUE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are registered one edge ahead of the ISSUE cycle that uses them:
    // on accept for gate 0, and on each non-final capture for the next gate.
    // This keeps mac_* glitch-free and stable for the whole issue/wait window.
    assign load_ops = accept | (capture & (gate_idx != 2'd3));
    assign load_idx = accept ? 2'd0 : (gate_idx + 2'd1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gate_idx <= 2'd0;
            wait_cnt <= '0;
            x_lat    <= '0;
            h_lat    <= '0;
            w0_q     <= '0;
            w1_q     <= '0;
            b_q      <= '0;
            // NOTE: the gate result array is explicitly cleared on reset
            // because an in-flight sample must not leak partial results.
            gate_q   <= '0;
        end else begin
            state <= state_next;

            if (accept) begin
                x_lat    <= x_in;
                h_lat    <= h_in;
                gate_idx <= 2'd0;
            end else if (capture && (gate_idx != 2'd3)) begin
                gate_idx <= gate_idx + 2'd1;
            end

            if (load_ops) begin
                w0_q <= w_cfg[(2 * int'(load_idx))     * DATA_WIDTH +: DATA_WIDTH];
                w1_q <= w_cfg[(2 * int'(load_idx) + 1) * DATA_WIDTH +: DATA_WIDTH];
                b_q  <= b_cfg[int'(load_idx) * DATA_WIDTH +: DATA_WIDTH];
            end

            if (capture) begin
                gate_q[gate_idx] <= mac_out;
            end

            if ((state == WAIT) && !capture) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign mac_x  = x_lat;
    assign mac_h  = h_lat;
    assign mac_w0 = w0_q;
    assign mac_w1 = w1_q;
    assign mac_b  = b_q;

    assign gate_i = gate_q[0];
    assign gate_f = gate_q[1];
    assign gate_g = gate_q[2];
    assign gate_o = gate_q[3];

endmodule

// File: tb/tb_lstm_gate_scheduler.sv
// ----------------------------------------------------------------------------
// tb_lstm_gate_scheduler
//
// Self-checking bench for lstm_gate_scheduler. Two instances share clock,
// reset and configuration: dut_a with a combinational model MAC
// (MAC_LATENCY=0) and dut_b with a 2-stage pipelined model MAC
// (MAC_LATENCY=2). The model MAC and the reference model both use Q8.8
// arithmetic: out = (W0*X >>> 8) + (W1*h >>> 8) + b, wrapped to 16 bits.
// ----------------------------------------------------------------------------
module tb_lstm_gate_scheduler;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [8*DW-1:0] w_cfg;
    logic [4*DW-1:0] b_cfg;

    // dut_a signals
    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [DW-1:0] a_x, a_h, a_mx, a_mh, a_mw0, a_mw1, a_mb, a_mout;
    logic [DW-1:0] a_gi, a_gf, a_gg, a_go;

    // dut_b signals
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [DW-1:0] b_x, b_h, b_mx, b_mh, b_mw0, b_mw1, b_mb, b_mout;
    logic [DW-1:0] b_gi, b_gf, b_gg, b_go;
    logic [DW-1:0] b_pipe1 = '0;
    logic [DW-1:0] b_pipe2 = '0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    function automatic logic [DW-1:0] mac_fn(input logic [DW-1:0] x, h, w0, w1, b);
        int p0, p1;
        p0 = int'($signed(w0)) * int'($signed(x));
        p1 = int'($signed(w1)) * int'($signed(h));
        return DW'((p0 >>> 8) + (p1 >>> 8) + int'($signed(b)));
    endfunction

    // Reference: all four gates from the sample and the configuration slices.
    function automatic logic [4*DW-1:0] ref_gates(input logic [DW-1:0] x, h);
        logic [4*DW-1:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*DW +: DW] = mac_fn(x, h, w_cfg[2*k*DW +: DW],
                                   w_cfg[(2*k+1)*DW +: DW], b_cfg[k*DW +: DW]);
        end
        return r;
    endfunction

    assign a_mout = mac_fn(a_mx, a_mh, a_mw0, a_mw1, a_mb);

    always @(posedge clk) begin
        b_pipe1 <= mac_fn(b_mx, b_mh, b_mw0, b_mw1, b_mb);
        b_pipe2 <= b_pipe1;
    end
    assign b_mout = b_pipe2;

    lstm_gate_scheduler #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .MAC_LATENCY(0)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .x_in(a_x), .h_in(a_h),
        .w_cfg(w_cfg), .b_cfg(b_cfg),
        .mac_x(a_mx), .mac_h(a_mh), .mac_w0(a_mw0), .mac_w1(a_mw1), .mac_b(a_mb),
        .mac_out(a_mout),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .gate_i(a_gi), .gate_f(a_gf), .gate_g(a_gg), .gate_o(a_go),
        .busy(a_busy)
    );

    lstm_gate_scheduler #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .MAC_LATENCY(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .x_in(b_x), .h_in(b_h),
        .w_cfg(w_cfg), .b_cfg(b_cfg),
        .mac_x(b_mx), .mac_h(b_mh), .mac_w0(b_mw0), .mac_w1(b_mw1), .mac_b(b_mb),
        .mac_out(b_mout),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .gate_i(b_gi), .gate_f(b_gf), .gate_g(b_gg), .gate_o(b_go),
        .busy(b_busy)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_spec_cfg();
        w_cfg = '0;
        b_cfg = '0;
        w_cfg[0*DW +: DW] = 16'h0200;
        w_cfg[1*DW +: DW] = 16'h0100;
        b_cfg[0*DW +: DW] = 16'h0010;
        for (int k = 1; k < 4; k++) begin
            w_cfg[2*k*DW +: DW]     = 16'h0100;
            w_cfg[(2*k+1)*DW +: DW] = 16'h0100;
        end
    endtask

    task automatic rand_cfg();
        // Keep weights within roughly +/-4.0 so products stay readable.
        for (int k = 0; k < 8; k++) w_cfg[k*DW +: DW] = DW'($signed($urandom_range(0, 2047)) - 1024);
        for (int k = 0; k < 4; k++) b_cfg[k*DW +: DW] = DW'($urandom);
    endtask

    task automatic wait_a_valid(input string tag, input int budget);
        int n = 0;
        while (!a_out_valid && n < budget) begin
            tick();
            n++;
        end
        check(tag, a_out_valid, 1'b1);
    endtask

    task automatic wait_b_valid(input string tag, input int budget);
        int n = 0;
        while (!b_out_valid && n < budget) begin
            tick();
            n++;
        end
        check(tag, b_out_valid, 1'b1);
    endtask

    logic [4*DW-1:0] exp_g;
    logic [4*DW-1:0] hold_g;
    logic [4*DW-1:0] exp_q[$];
    int              acc_cyc[$];
    int              n_acc, n_out, start;
    logic [DW-1:0]   tx, th;

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_x = '0; a_h = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_x = '0; b_h = '0;
        set_spec_cfg();
        tick();
        tick();

        // ---------------- reset state ----------------
        check("reset_in_ready",  a_in_ready, 1'b1);
        check("reset_out_valid", a_out_valid, 1'b0);
        check("reset_busy",      a_busy, 1'b0);
        check("reset_gates",     {a_go, a_gg, a_gf, a_gi}, 64'h0);
        check("reset_mac",       {a_mx, a_mh, a_mw0, a_mw1, a_mb}, 80'h0);
        rst = 1'b0;
        tick();

        // ---------------- single sample, spec vector, MAC_LATENCY=0 ----------------
        a_x = 16'h0100; a_h = 16'h0080; a_in_valid = 1'b1;
        check("accept_ready", a_in_ready, 1'b1);
        tick();
        a_in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("seq_w0_c%0d", c), a_mw0, w_cfg[2*(c-1)*DW +: DW]);
            check($sformatf("seq_w1_c%0d", c), a_mw1, w_cfg[(2*(c-1)+1)*DW +: DW]);
            check($sformatf("seq_b_c%0d", c),  a_mb,  b_cfg[(c-1)*DW +: DW]);
            check($sformatf("seq_xh_c%0d", c), {a_mx, a_mh}, {16'h0100, 16'h0080});
            check($sformatf("seq_ov_c%0d", c), a_out_valid, 1'b0);
            check($sformatf("seq_busy_c%0d", c), a_busy, 1'b1);
            tick();
        end
        check("single_out_valid_c5", a_out_valid, 1'b1);
        check("single_gates_const", {a_go, a_gg, a_gf, a_gi},
              {16'h0180, 16'h0180, 16'h0180, 16'h0290});
        check("single_gates_model", {a_go, a_gg, a_gf, a_gi}, ref_gates(16'h0100, 16'h0080));

        // ---------------- backpressure ----------------
        hold_g = {16'h0180, 16'h0180, 16'h0180, 16'h0290};
        tx = DW'($urandom); th = DW'($urandom);
        a_x = tx; a_h = th; a_in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_out_valid", a_out_valid, 1'b1);
            check("bp_in_ready",  a_in_ready, 1'b0);
            check("bp_gates",     {a_go, a_gg, a_gf, a_gi}, hold_g);
        end
        a_out_ready = 1'b1;
        tick();
        check("bp_release_idle",  a_in_ready, 1'b1);
        check("bp_release_ov",    a_out_valid, 1'b0);
        tick();
        check("bp_second_accept", a_busy, 1'b1);
        check("bp_second_x",      {a_mx, a_mh}, {tx, th});
        a_in_valid = 1'b0;
        exp_g = ref_gates(tx, th);
        wait_a_valid("bp_second_timeout", 20);
        check("bp_second_gates", {a_go, a_gg, a_gf, a_gi}, exp_g);
        tick();

        // ---------------- reset mid-DONE ----------------
        a_out_ready = 1'b0;
        a_x = DW'($urandom); a_h = DW'($urandom); a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        wait_a_valid("rst_done_timeout", 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_done_out_valid", a_out_valid, 1'b0);
        check("rst_done_gates",     {a_go, a_gg, a_gf, a_gi}, 64'h0);
        check("rst_done_in_ready",  a_in_ready, 1'b1);
        check("rst_done_busy",      a_busy, 1'b0);

        // ---------------- reset mid-ISSUE ----------------
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_issue_gates", {a_go, a_gg, a_gf, a_gi}, 64'h0);
        check("rst_issue_idle",  {a_in_ready, a_busy}, 2'b10);

        // ---------------- back-to-back, random config and samples ----------------
        rand_cfg();
        a_out_ready = 1'b1;
        n_acc = 0;
        n_out = 0;
        for (int c = 0; c < 200 && n_out < 5; c++) begin
            if (a_out_valid) begin
                if (exp_q.size() > 0) begin
                    check($sformatf("b2b_gates_%0d", n_out), {a_go, a_gg, a_gf, a_gi}, exp_q.pop_front());
                end else begin
                    check("b2b_unexpected_output", 1'b1, 1'b0);
                end
                n_out++;
            end
            if (a_in_ready && n_acc < 5) begin
                a_x = DW'($urandom); a_h = DW'($urandom);
                a_in_valid = 1'b1;
                exp_q.push_back(ref_gates(a_x, a_h));
                acc_cyc.push_back(cyc);
                if (n_acc > 0) begin
                    check($sformatf("b2b_spacing_%0d", n_acc), acc_cyc[n_acc] - acc_cyc[n_acc-1], 6);
                end
                n_acc++;
            end else if (n_acc >= 5) begin
                a_in_valid = 1'b0;
            end
            tick();
        end
        a_in_valid = 1'b0;
        check("b2b_output_count", n_out, 5);

        // ---------------- MAC_LATENCY=2 instance ----------------
        set_spec_cfg();
        b_x = 16'h0100; b_h = 16'h0080; b_in_valid = 1'b1;
        check("lat2_accept_ready", b_in_ready, 1'b1);
        tick();
        b_in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("lat2_ops_c%0d", c), {b_mw0, b_mw1, b_mb},
                  {w_cfg[2*((c-1)/3)*DW +: DW], w_cfg[(2*((c-1)/3)+1)*DW +: DW],
                   b_cfg[((c-1)/3)*DW +: DW]});
            check($sformatf("lat2_ov_c%0d", c), b_out_valid, 1'b0);
            tick();
        end
        check("lat2_out_valid_c13", b_out_valid, 1'b1);
        check("lat2_gates_const", {b_go, b_gg, b_gf, b_gi},
              {16'h0180, 16'h0180, 16'h0180, 16'h0290});
        b_out_ready = 1'b1;
        tick();
        check("lat2_back_idle", b_in_ready, 1'b1);

        rand_cfg();
        b_x = DW'($urandom); b_h = DW'($urandom); b_in_valid = 1'b1;
        exp_g = ref_gates(b_x, b_h);
        start = cyc;
        tick();
        b_in_valid = 1'b0;
        wait_b_valid("lat2_rand_timeout", 40);
        check("lat2_rand_latency", cyc - start, 13);
        check("lat2_rand_gates", {b_go, b_gg, b_gf, b_gi}, exp_g);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
